sb_master_arbiter: RTL and testbench

Two-master arbiter for the shared system bus. It sequences bus ownership between the JTAG debug bridge (master 0) and a second bus master such as the CPU (master 1). It uses round-robin request/grant, holds each grant until the transaction ends, and has a watchdog that reclaims the bus from a stalled owner. It sits between the masters' `sb_request_o`/`sb_grant_i` pins and the bus. It drives control only; the masters' bus outputs are OR-combined externally while not granted (idle low).

---
 rtl/sb_master_arbiter.sv | 172 +++++++++++++++++
 tb/tb_sb_master_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sb_master_arbiter.sv
// sb_master_arbiter
//
// Two-master arbiter for the shared system bus. Master 0 is the JTAG debug
// bridge and master 1 is the second bus master (e.g. the CPU). The grant goes
// round-robin and is held until the transaction ends. A watchdog reclaims the
// bus from an owner that makes no progress for TIMEOUT_CYCLES cycles.
//
// Ports:
//   sb_clock_i             system bus clock
//   sb_reset_n_i           asynchronous active-low reset
//   m_request_i[1:0]       per-master level request (bit 0 debug, bit 1 CPU)
//   m_begin_transaction_i  per-master begin_transaction pulse
//   m_end_transaction_i    per-master end_transaction (master-terminated writes)
//   m_data_valid_i         per-master data_valid
//   sb_end_transaction_i   slave-driven end_transaction
//   sb_data_valid_i        slave-driven data_valid
//   sb_error_i             bus error
//   m_grant_o[1:0]         registered one-hot-or-zero grant
//   owner_o                index of the current or last owner
//   bus_busy_o             high whenever the arbiter is not idle
//   timeout_o              one-cycle pulse when the watchdog fires
//   error_o                one-cycle pulse when a transaction ends on error
//
// All outputs come from registers; there are no input-to-output comb paths.

module sb_master_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 16
) (
  input  logic       sb_clock_i,
  input  logic       sb_reset_n_i,
  input  logic [1:0] m_request_i,
  input  logic [1:0] m_begin_transaction_i,
  input  logic [1:0] m_end_transaction_i,
  input  logic [1:0] m_data_valid_i,
  input  logic       sb_end_transaction_i,
  input  logic       sb_data_valid_i,
  input  logic       sb_error_i,
  output logic [1:0] m_grant_o,
  output logic       owner_o,
  output logic       bus_busy_o,
  output logic       timeout_o,
  output logic       error_o
);

  typedef enum logic [1:0] {
    StIdle,
    StGranted,
    StActive
  } state_e;

  localparam logic [CNT_W-1:0] CntLimit = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntMax   = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             error_q, error_d;

  // Only the owner's signals matter once granted; the other master is ignored.
  logic             own_req;
  logic             own_begin;
  logic             xfer_end;
  logic             progress;
  logic             cnt_at_limit;
  logic [CNT_W-1:0] cnt_inc;
  logic             sel;

  assign own_req      = m_request_i[owner_q];
  assign own_begin    = m_begin_transaction_i[owner_q];
  assign xfer_end     = m_end_transaction_i[owner_q] | sb_end_transaction_i | sb_error_i;
  assign progress     = m_data_valid_i[owner_q] | sb_data_valid_i;
  assign cnt_at_limit = (cnt_q == CntLimit);
  // Saturating increment: the watchdog counter never wraps.
  assign cnt_inc      = (cnt_q == CntMax) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    error_d   = 1'b0;
    sel       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (|m_request_i) begin
          // On a tie the master that did not win last time goes next.
          sel     = (&m_request_i) ? ~last_q : m_request_i[1];
          state_d = StGranted;
          grant_d = sel ? 2'b10 : 2'b01;
          owner_d = sel;
          last_d  = sel;
          cnt_d   = '0;
        end
      end

      StGranted: begin
        if (own_begin && xfer_end) begin
          state_d = StIdle;
          grant_d = '0;
        end else if (own_begin) begin
          state_d = StActive;
          cnt_d   = '0;
        end else if (cnt_at_limit) begin
          state_d   = StIdle;
          grant_d   = '0;
          timeout_d = 1'b1;
        end else if (!own_req) begin
          // Owner gave up the grant without starting a transaction.
          state_d = StIdle;
          grant_d = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      StActive: begin
        if (xfer_end) begin
          state_d = StIdle;
          grant_d = '0;
          error_d = sb_error_i;
        end else if (progress) begin
          cnt_d = '0;
        end else if (cnt_at_limit) begin
          state_d   = StIdle;
          grant_d   = '0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge sb_clock_i or negedge sb_reset_n_i) begin
    if (!sb_reset_n_i) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;  // master 0 wins the first tie
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      error_q   <= error_d;
    end
  end

  assign m_grant_o  = grant_q;
  assign owner_o    = owner_q;
  assign bus_busy_o = (state_q != StIdle);
  assign timeout_o  = timeout_q;
  assign error_o    = error_q;

endmodule

// File: tb/tb_sb_master_arbiter.sv
module tb_sb_master_arbiter;

  logic       clk;
  logic       rst_n;
  logic [1:0] m_req;
  logic [1:0] m_begin;
  logic [1:0] m_end;
  logic [1:0] m_dv;
  logic       sb_end;
  logic       sb_dv;
  logic       sb_err;
  logic [1:0] grant;
  logic       owner;
  logic       busy;
  logic       tmo;
  logic       err;

  int checks;
  int failures;

  sb_master_arbiter #(
    .TIMEOUT_CYCLES(8),
    .CNT_W         (16)
  ) dut (
    .sb_clock_i           (clk),
    .sb_reset_n_i         (rst_n),
    .m_request_i          (m_req),
    .m_begin_transaction_i(m_begin),
    .m_end_transaction_i  (m_end),
    .m_data_valid_i       (m_dv),
    .sb_end_transaction_i (sb_end),
    .sb_data_valid_i      (sb_dv),
    .sb_error_i           (sb_err),
    .m_grant_o            (grant),
    .owner_o              (owner),
    .bus_busy_o           (busy),
    .timeout_o            (tmo),
    .error_o              (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; m_req = '0; m_begin = '0; m_end = '0; m_dv = '0;
    sb_end = 1'b0; sb_dv = 1'b0; sb_err = 1'b0;
    step();
    step();
    checks++;
    if ({grant, owner, busy, tmo, err} !== 6'b0) begin
      failures++;
      $display("FAIL reset_outputs: grant=%b owner=%b busy=%b tmo=%b err=%b required all 0",
               grant, owner, busy, tmo, err);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_grant();
    m_req = 2'b01;
    step();
    checks++;
    if (grant !== 2'b01 || busy !== 1'b1 || owner !== 1'b0) begin
      failures++;
      $display("FAIL single_grant: grant=%b busy=%b owner=%b required 01 1 0", grant, busy, owner);
    end
    step();
    m_begin = 2'b01;
    step();
    m_begin = 2'b00;
    m_req   = 2'b00;
    checks++;
    if (grant !== 2'b01 || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_active: grant=%b busy=%b required 01 1", grant, busy);
    end
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (grant !== 2'b01 || tmo !== 1'b0) begin
      failures++;
      $display("FAIL single_hold: grant=%b tmo=%b required 01 0", grant, tmo);
    end
    m_end = 2'b01;
    step();
    m_end = 2'b00;
    checks++;
    if (grant !== 2'b00 || busy !== 1'b0 || owner !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL single_end: grant=%b busy=%b owner=%b err=%b required 00 0 0 0",
               grant, busy, owner, err);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_g;
    test_reset();
    m_req = 2'b11;
    step();
    checks++;
    if (grant !== 2'b01) begin
      failures++;
      $display("FAIL rr_first: grant=%b required 01", grant);
    end
    for (int i = 0; i < 4; i++) begin
      m_begin = (i % 2 == 0) ? 2'b01 : 2'b10;
      m_end   = m_begin;
      step();
      m_begin = 2'b00;
      m_end   = 2'b00;
      checks++;
      if (grant !== 2'b00 || busy !== 1'b0) begin
        failures++;
        $display("FAIL rr_turnaround%0d: grant=%b busy=%b required 00 0", i, grant, busy);
      end
      step();
      exp_g = (i % 2 == 0) ? 2'b10 : 2'b01;
      checks++;
      if (grant !== exp_g) begin
        failures++;
        $display("FAIL rr_grant%0d: grant=%b required %b", i, grant, exp_g);
      end
    end
    // Master 0 holds the grant; dropping requests abandons it.
    m_req = 2'b00;
    step();
    checks++;
    if (grant !== 2'b00 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rr_abandon: grant=%b busy=%b required 00 0", grant, busy);
    end
  endtask

  task automatic test_timeout_granted();
    m_req = 2'b10;
    step();
    checks++;
    if (grant !== 2'b10 || owner !== 1'b1) begin
      failures++;
      $display("FAIL tmo_grant: grant=%b owner=%b required 10 1", grant, owner);
    end
    m_req = 2'b11;
    for (int j = 1; j < 8; j++) begin
      m_begin = (j == 3) ? 2'b01 : 2'b00;  // non-owner begin must be ignored
      step();
      checks++;
      if (tmo !== 1'b0 || grant !== 2'b10) begin
        failures++;
        $display("FAIL tmo_wait%0d: tmo=%b grant=%b required 0 10", j, tmo, grant);
      end
    end
    m_begin = 2'b00;
    step();
    checks++;
    if (tmo !== 1'b1 || grant !== 2'b00 || busy !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL tmo_fire: tmo=%b grant=%b busy=%b err=%b required 1 00 0 0",
               tmo, grant, busy, err);
    end
    step();
    checks++;
    if (tmo !== 1'b0 || grant !== 2'b01) begin
      failures++;
      $display("FAIL tmo_next: tmo=%b grant=%b required 0 01", tmo, grant);
    end
    m_req = 2'b00;
    step();
  endtask

  task automatic test_burst();
    int bad;
    bad = 0;
    m_req = 2'b01;
    step();
    m_begin = 2'b01;
    step();
    m_begin = 2'b00;
    m_req   = 2'b00;
    for (int i = 0; i < 100; i++) begin
      sb_dv = (i % 5 == 4);
      step();
      checks++;
      if (tmo !== 1'b0 || grant !== 2'b01) begin
        failures++;
        bad++;
        if (bad < 4) $display("FAIL burst_hold%0d: tmo=%b grant=%b required 0 01", i, tmo, grant);
      end
    end
    sb_dv  = 1'b0;
    sb_end = 1'b1;
    step();
    sb_end = 1'b0;
    checks++;
    if (grant !== 2'b00 || busy !== 1'b0 || tmo !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL burst_end: grant=%b busy=%b tmo=%b err=%b required 00 0 0 0",
               grant, busy, tmo, err);
    end
  endtask

  task automatic test_progress_at_limit();
    m_req = 2'b10;
    step();
    m_begin = 2'b10;
    step();
    m_begin = 2'b00;
    m_req   = 2'b00;
    for (int i = 0; i < 7; i++) step();
    checks++;
    if (tmo !== 1'b0 || grant !== 2'b10) begin
      failures++;
      $display("FAIL limit_pre: tmo=%b grant=%b required 0 10", tmo, grant);
    end
    m_dv = 2'b10;  // progress on the very cycle the counter is at its limit
    step();
    checks++;
    if (tmo !== 1'b0 || grant !== 2'b10) begin
      failures++;
      $display("FAIL limit_progress: tmo=%b grant=%b required 0 10", tmo, grant);
    end
    m_dv = 2'b01;  // non-owner data_valid is not progress
    for (int i = 0; i < 7; i++) step();
    checks++;
    if (tmo !== 1'b0 || grant !== 2'b10) begin
      failures++;
      $display("FAIL limit_wait: tmo=%b grant=%b required 0 10", tmo, grant);
    end
    step();
    m_dv = 2'b00;
    checks++;
    if (tmo !== 1'b1 || grant !== 2'b00 || busy !== 1'b0) begin
      failures++;
      $display("FAIL limit_fire: tmo=%b grant=%b busy=%b required 1 00 0", tmo, grant, busy);
    end
    step();
    checks++;
    if (tmo !== 1'b0 || owner !== 1'b1) begin
      failures++;
      $display("FAIL limit_after: tmo=%b owner=%b required 0 1", tmo, owner);
    end
  endtask

  task automatic test_error();
    m_req = 2'b01;
    step();
    m_begin = 2'b01;
    step();
    m_begin = 2'b00;
    m_req   = 2'b00;
    step();
    sb_err = 1'b1;
    step();
    sb_err = 1'b0;
    checks++;
    if (err !== 1'b1 || grant !== 2'b00 || tmo !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL error_pulse: err=%b grant=%b tmo=%b busy=%b required 1 00 0 0",
               err, grant, tmo, busy);
    end
    step();
    checks++;
    if (err !== 1'b0 || tmo !== 1'b0) begin
      failures++;
      $display("FAIL error_once: err=%b tmo=%b required 0 0", err, tmo);
    end
  endtask

  task automatic test_async_reset();
    m_req = 2'b10;
    step();
    m_begin = 2'b10;
    step();
    m_begin = 2'b00;
    m_req   = 2'b00;
    step();
    checks++;
    if (grant !== 2'b10 || busy !== 1'b1) begin
      failures++;
      $display("FAIL arst_pre: grant=%b busy=%b required 10 1", grant, busy);
    end
    rst_n = 1'b0;
    #2;
    checks++;
    if ({grant, busy, tmo, err} !== 5'b0) begin
      failures++;
      $display("FAIL arst_clear: grant=%b busy=%b tmo=%b err=%b required all 0",
               grant, busy, tmo, err);
    end
    step();
    rst_n = 1'b1;
    step();
    m_req = 2'b11;
    step();
    checks++;
    if (grant !== 2'b01 || owner !== 1'b0) begin
      failures++;
      $display("FAIL arst_first_tie: grant=%b owner=%b required 01 0", grant, owner);
    end
    m_req = 2'b00;
    step();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    test_reset();
    test_single_grant();
    test_back_to_back();
    test_timeout_granted();
    test_burst();
    test_progress_at_limit();
    test_error();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
